// File: rtl/aqed_fifo_fc_monitor.sv
// A-QED monitor for a FIFO-mode memory core: tags an original/duplicate input
// pair, checks their outputs for consistency and bounds the original's latency.
module aqed_fifo_fc_monitor #(
  parameter int DATA_W         = 16,
  parameter int CNT_W          = 17,
  parameter int BOUND_MULT     = 4,
  parameter int CHECK_IDENTITY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clk_en,
  input  logic              flush,
  input  logic [15:0]       depth,
  input  logic              wen_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic              sel_orig,
  input  logic              sel_dup,
  input  logic              valid_out,
  input  logic              ren_in,
  input  logic [DATA_W-1:0] data_out,
  output logic              orig_issued,
  output logic              dup_issued,
  output logic              qed_done,
  output logic              qed_check,
  output logic              bound_fail,
  output logic [CNT_W-1:0]  in_count,
  output logic [CNT_W-1:0]  out_count
);

  localparam int RW = CNT_W + 8;
  localparam int PW = (RW > 24) ? RW : 24;
  localparam logic [7:0] MULT = 8'(BOUND_MULT);

  typedef enum logic [1:0] {
    IDLE,
    ORIG,
    DUP,
    DONE
  } st_t;

  st_t st;

  logic              in_xfer;
  logic              out_xfer;
  logic              in_sat;
  logic              rd_sat;
  logic              take_orig;
  logic              take_dup;
  logic              got_orig;
  logic              got_dup;
  logic              check_c;
  logic              bound_c;
  logic [CNT_W-1:0]  orig_idx;
  logic [CNT_W-1:0]  dup_idx;
  logic [DATA_W-1:0] orig_data;
  logic [DATA_W-1:0] orig_out;
  logic [DATA_W-1:0] dup_out;
  logic              orig_got;
  logic              dup_got;
  logic [RW-1:0]     rd_after;
  logic [PW-1:0]     bound_lim;
  logic [PW-1:0]     rd_ext;

  assign in_xfer  = clk_en & wen_in;
  assign out_xfer = clk_en & valid_out & ren_in;
  assign in_sat   = &in_count;
  assign rd_sat   = &rd_after;

  // A saturated input counter no longer names a unique transfer
  assign take_orig = in_xfer & sel_orig & ~in_sat
                   & (st == IDLE);
  assign take_dup  = in_xfer & sel_dup & ~in_sat
                   & (st == ORIG)
                   & (data_in == orig_data);

  assign got_orig = out_xfer & orig_issued & ~orig_got
                  & (out_count == orig_idx);
  assign got_dup  = out_xfer & dup_issued & ~dup_got
                  & (out_count == dup_idx);

  assign check_c = (orig_out == dup_out)
                 & ((CHECK_IDENTITY == 0)
                    | (orig_out == orig_data));

  // Full-width product so a large depth never wraps the limit
  assign bound_lim = PW'(depth) * PW'(MULT);
  assign rd_ext    = PW'(rd_after);
  assign bound_c   = (depth != '0) & ~orig_got
                   & (rd_ext >= bound_lim);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st          <= IDLE;
      orig_issued <= 1'b0;
      dup_issued  <= 1'b0;
      qed_done    <= 1'b0;
      qed_check   <= 1'b0;
      orig_data   <= '0;
      orig_idx    <= '0;
      dup_idx     <= '0;
    end else if (flush) begin
      st          <= IDLE;
      orig_issued <= 1'b0;
      dup_issued  <= 1'b0;
      qed_done    <= 1'b0;
      qed_check   <= 1'b0;
      orig_data   <= '0;
      orig_idx    <= '0;
      dup_idx     <= '0;
    end else if (clk_en) begin
      unique case (st)
        IDLE: begin
          if (take_orig) begin
            orig_data   <= data_in;
            orig_idx    <= in_count;
            orig_issued <= 1'b1;
            st          <= ORIG;
          end
        end
        ORIG: begin
          if (take_dup) begin
            dup_idx    <= in_count;
            dup_issued <= 1'b1;
            st         <= DUP;
          end
        end
        DUP: begin
          if (orig_got & dup_got) begin
            qed_done  <= 1'b1;
            qed_check <= check_c;
            st        <= DONE;
          end
        end
        DONE: begin
          st <= DONE;
        end
        default: begin
          st <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      orig_got <= 1'b0;
      dup_got  <= 1'b0;
      orig_out <= '0;
      dup_out  <= '0;
    end else if (flush) begin
      orig_got <= 1'b0;
      dup_got  <= 1'b0;
      orig_out <= '0;
      dup_out  <= '0;
    end else if (clk_en) begin
      if (got_orig) begin
        orig_out <= data_out;
        orig_got <= 1'b1;
      end
      if (got_dup) begin
        dup_out <= data_out;
        dup_got <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_count  <= '0;
      out_count <= '0;
    end else if (flush) begin
      in_count  <= '0;
      out_count <= '0;
    end else if (clk_en) begin
      if (in_xfer & ~in_sat)
        in_count <= in_count + CNT_W'(1);
      if (out_xfer & ~(&out_count))
        out_count <= out_count + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_after   <= '0;
      bound_fail <= 1'b0;
    end else if (flush) begin
      rd_after   <= '0;
      bound_fail <= 1'b0;
    end else if (clk_en) begin
      if (out_xfer & orig_issued & ~orig_got & ~rd_sat)
        rd_after <= rd_after + RW'(1);
      if (bound_c)
        bound_fail <= 1'b1;
    end
  end

endmodule

// File: tb/tb_aqed_fifo_fc_monitor.sv
// Randomized and directed bench for aqed_fifo_fc_monitor with a
// transaction-level reference model.
module tb_aqed_fifo_fc_monitor;

  localparam int DW = 16;
  localparam int CW = 17;
  localparam int BM = 4;
  localparam longint MAXC = (longint'(1) << CW) - 1;

  logic clk = 0;
  logic reset = 0;
  always #5 clk = ~clk;

  logic          clk_en = 1;
  logic          flush = 0;
  logic [15:0]   depth = 0;
  logic          wen_in = 0;
  logic [DW-1:0] data_in = 0;
  logic          sel_orig = 0;
  logic          sel_dup = 0;
  logic          valid_out = 0;
  logic          ren_in = 0;
  logic [DW-1:0] data_out = 0;
  logic          orig_issued, dup_issued, qed_done, qed_check, bound_fail;
  logic [CW-1:0] in_count, out_count;

  aqed_fifo_fc_monitor #(
    .DATA_W(DW), .CNT_W(CW), .BOUND_MULT(BM), .CHECK_IDENTITY(1)
  ) dut (
    .clk(clk), .reset(reset), .clk_en(clk_en), .flush(flush),
    .depth(depth), .wen_in(wen_in), .data_in(data_in),
    .sel_orig(sel_orig), .sel_dup(sel_dup), .valid_out(valid_out),
    .ren_in(ren_in), .data_out(data_out),
    .orig_issued(orig_issued), .dup_issued(dup_issued),
    .qed_done(qed_done), .qed_check(qed_check),
    .bound_fail(bound_fail), .in_count(in_count), .out_count(out_count)
  );

  logic       s_wen = 0;
  logic [7:0] s_data = 0;
  logic       s_sel_orig = 0;
  logic       s_orig_issued, s_dup_issued, s_qed_done, s_qed_check;
  logic       s_bound_fail;
  logic [2:0] s_in_count, s_out_count;

  aqed_fifo_fc_monitor #(
    .DATA_W(8), .CNT_W(3), .BOUND_MULT(BM), .CHECK_IDENTITY(1)
  ) sdut (
    .clk(clk), .reset(reset), .clk_en(1'b1), .flush(1'b0),
    .depth(16'd1), .wen_in(s_wen), .data_in(s_data),
    .sel_orig(s_sel_orig), .sel_dup(1'b0), .valid_out(1'b0),
    .ren_in(1'b0), .data_out(8'd0),
    .orig_issued(s_orig_issued), .dup_issued(s_dup_issued),
    .qed_done(s_qed_done), .qed_check(s_qed_check),
    .bound_fail(s_bound_fail), .in_count(s_in_count),
    .out_count(s_out_count)
  );

  int checks = 0;
  int errors = 0;
  bit chk_on = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: transaction events tracked by index
  longint m_in, m_out, m_oidx, m_didx, m_rd;
  bit m_oi, m_di, m_og, m_dg, m_done, m_chk, m_bf;
  logic [DW-1:0] m_odata, m_oout, m_dout;

  always @(posedge clk or posedge reset) begin
    bit ix, ox, t_o, t_d, g_o, g_d, fin, bnd, cr;
    if (reset || flush) begin
      m_in = 0; m_out = 0; m_oidx = 0; m_didx = 0; m_rd = 0;
      m_oi = 0; m_di = 0; m_og = 0; m_dg = 0;
      m_done = 0; m_chk = 0; m_bf = 0;
      m_odata = 0; m_oout = 0; m_dout = 0;
    end else if (clk_en) begin
      ix  = wen_in;
      ox  = valid_out && ren_in;
      t_o = !m_oi && ix && sel_orig && m_in != MAXC;
      t_d = m_oi && !m_di && ix && sel_dup && m_in != MAXC
            && data_in == m_odata;
      g_o = m_oi && !m_og && ox && m_out == m_oidx;
      g_d = m_di && !m_dg && ox && m_out == m_didx;
      fin = m_og && m_dg && !m_done;
      bnd = depth != 0 && !m_og && m_rd >= longint'(BM) * longint'(depth);
      cr  = m_oi && !m_og && ox;
      if (fin) begin
        m_done = 1;
        m_chk  = (m_oout == m_dout) && (m_oout == m_odata);
      end
      if (bnd) m_bf = 1;
      if (cr) m_rd++;
      if (g_o) begin m_og = 1; m_oout = data_out; end
      if (g_d) begin m_dg = 1; m_dout = data_out; end
      if (t_o) begin m_oi = 1; m_odata = data_in; m_oidx = m_in; end
      if (t_d) begin m_di = 1; m_didx = m_in; end
      if (ix && m_in != MAXC) m_in++;
      if (ox && m_out != MAXC) m_out++;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("orig_issued", orig_issued, m_oi);
      chk("dup_issued", dup_issued, m_di);
      chk("qed_done", qed_done, m_done);
      chk("qed_check", qed_check, m_chk);
      chk("bound_fail", bound_fail, m_bf);
      chk("in_count", in_count, m_in);
      chk("out_count", out_count, m_out);
    end
  end

  task automatic step(input bit w, input logic [DW-1:0] d, input bit so,
                      input bit sd, input bit v, input bit r,
                      input logic [DW-1:0] dout);
    wen_in = w; data_in = d; sel_orig = so; sel_dup = sd;
    valid_out = v; ren_in = r; data_out = dout;
    @(negedge clk);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_flush();
    flush = 1;
    idle();
    flush = 0;
  endtask

  task automatic tagged_writes();
    step(1, 16'hA1, 1, 0, 0, 0, 0);
    step(1, 16'hB2, 0, 0, 0, 0, 0);
    step(1, 16'hA1, 0, 1, 0, 0, 0);
  endtask

  logic [DW-1:0] fifo_q[$];

  initial begin
    reset = 1;
    @(negedge clk);
    @(negedge clk);
    reset = 0;
    chk_on = 1;
    chk("rst_done", qed_done, 0);
    chk("rst_in_count", in_count, 0);
    chk("rst_orig", orig_issued, 0);

    // identity pass
    depth = 4;
    tagged_writes();
    chk("id_dup_issued", dup_issued, 1);
    step(0, 0, 0, 0, 1, 1, 16'hA1);
    step(0, 0, 0, 0, 1, 1, 16'hB2);
    step(0, 0, 0, 0, 1, 1, 16'hA1);
    chk("id_done_early", qed_done, 0);
    idle();
    chk("id_done", qed_done, 1);
    chk("id_check", qed_check, 1);
    chk("id_in_count", in_count, 3);
    chk("id_out_count", out_count, 3);
    idle();
    chk("id_done_sticky", qed_done, 1);

    // consistency fail
    do_flush();
    tagged_writes();
    step(0, 0, 0, 0, 1, 1, 16'hA1);
    step(0, 0, 0, 0, 1, 1, 16'hB2);
    step(0, 0, 0, 0, 1, 1, 16'hA0);
    idle();
    chk("cf_done", qed_done, 1);
    chk("cf_check", qed_check, 0);

    // response bound, then the same with depth 0
    for (int pass = 0; pass < 2; pass++) begin
      do_flush();
      depth = (pass == 0) ? 16'd2 : 16'd0;
      for (int i = 0; i < 6; i++)
        step(1, 16'(i), i == 5, 0, 1, 1, 16'(i));
      for (int i = 0; i < 8; i++)
        step(1, 16'(i + 6), 0, 0, 1, 1, 16'(i + 6));
      if (pass == 0) chk("bf_early", bound_fail, 0);
      idle();
      chk(pass == 0 ? "bf_set" : "bf_depth0", bound_fail, pass == 0);
      idle(); idle(); idle();
      chk(pass == 0 ? "bf_sticky" : "bf_depth0_hold", bound_fail, pass == 0);
    end

    // select priority and data mismatch
    do_flush();
    depth = 4;
    step(1, 16'h11, 1, 1, 0, 0, 0);
    chk("pr_orig", orig_issued, 1);
    chk("pr_dup", dup_issued, 0);
    step(1, 16'h12, 0, 1, 0, 0, 0);
    chk("mm_dup", dup_issued, 0);
    step(1, 16'h11, 0, 1, 0, 0, 0);
    chk("match_dup", dup_issued, 1);

    // async reset mid-check
    do_flush();
    tagged_writes();
    step(0, 0, 0, 0, 1, 1, 16'hA1);
    #2 reset = 1;
    #1;
    chk("ar_orig", orig_issued, 0);
    chk("ar_dup", dup_issued, 0);
    chk("ar_in_count", in_count, 0);
    chk("ar_out_count", out_count, 0);
    @(negedge clk);
    reset = 0;

    // clk_en freeze, then flush with clk_en low
    tagged_writes();
    clk_en = 0;
    step(1, 16'h55, 1, 0, 1, 1, 0);
    chk("ce_freeze", in_count, 3);
    flush = 1;
    idle();
    flush = 0;
    chk("fl_dup", dup_issued, 0);
    chk("fl_in_count", in_count, 0);
    clk_en = 1;

    // saturation on the narrow instance
    for (int i = 0; i < 7; i++) begin
      s_wen = 1; s_data = 8'(i);
      @(negedge clk);
    end
    chk("sat_count", s_in_count, 7);
    s_sel_orig = 1;
    @(negedge clk);
    s_wen = 0; s_sel_orig = 0;
    chk("sat_count_hold", s_in_count, 7);
    chk("sat_no_orig", s_orig_issued, 0);

    // randomized FIFO traffic
    flush = 1;
    fifo_q.delete();
    for (int c = 0; c < 4000; c++) begin
      if (c != 0) flush = ($urandom_range(0, 299) == 0);
      if (flush) begin
        depth = 16'($urandom_range(0, 3));
        fifo_q.delete();
      end
      clk_en    = ($urandom_range(0, 9) != 0);
      wen_in    = $urandom_range(0, 1);
      data_in   = 16'(16'h40 + $urandom_range(0, 3));
      sel_orig  = ($urandom_range(0, 5) == 0);
      sel_dup   = ($urandom_range(0, 2) == 0);
      valid_out = (fifo_q.size() > 0);
      ren_in    = ($urandom_range(0, 9) < 7);
      data_out  = valid_out ? fifo_q[0] : 16'($urandom);
      if (valid_out && $urandom_range(0, 9) == 0) data_out ^= 16'h1;
      if (!flush && clk_en) begin
        if (valid_out && ren_in) void'(fifo_q.pop_front());
        if (wen_in) fifo_q.push_back(data_in);
      end
      @(negedge clk);
    end
    flush = 0;
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
